// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux8_rr_arbiter
//  Brief    : Round-robin arbiter and select controller for an 8:1 mux.
//             Each requester keeps exclusive ownership of the mux select
//             until it drops its request. Priority rotates to the index
//             after the owner that released, so no requester starves.
//             All outputs are registered.
//  Options  : `define MUX8_ARB_TIMEOUT_EN enables the hold-time limit.
//             After MAX_HOLD grant cycles the owner is rotated away, but
//             only when another requester is waiting.
//  Revision : 1.0 - initial release
// ============================================================================
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       preempt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Reject an out-of-range hold limit at elaboration time.
  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range_err
      $error("mux8_rr_arbiter: MAX_HOLD must be within 2..255");
    end
  endgenerate

  logic [0:0] state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       preempt_q, preempt_d;

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

  // Search inputs and result.
  logic [7:0] srch_req;
  logic [2:0] srch_ptr;
  logic [2:0] srch_idx;
  logic       win_found;
  logic [2:0] win_idx;

  // Pick the first requester at or after the search pointer. While a grant
  // is active, the owner is masked out and the search starts at owner+1.
  // This one search covers a release and a forced rotation alike.
  always_comb begin
    srch_req  = req;
    srch_ptr  = ptr_q;
    srch_idx  = 3'd0;
    win_found = 1'b0;
    win_idx   = 3'd0;
    if (state_q == ST_GRANT) begin
      srch_req = req & ~gnt_q;
      srch_ptr = sel_q + 3'd1;
    end
    // Walk from the farthest offset to the nearest, so the nearest hit wins.
    for (int k = 7; k >= 0; k--) begin
      srch_idx = srch_ptr + 3'(k);
      if (srch_req[srch_idx]) begin
        win_found = 1'b1;
        win_idx   = srch_idx;
      end
    end
  end

  // Next state: acquire from idle, hold, hand off on release, or time out.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    preempt_d = 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_GRANT;
          sel_d   = win_idx;
`ifdef MUX8_ARB_TIMEOUT_EN
          hold_cnt_d = 8'd0;
`endif
        end
      end
      ST_GRANT: begin
        if (!req[sel_q]) begin
          // Release: the next index gets top priority. Hand off directly
          // when anyone is waiting, so there is no idle bubble.
          ptr_d = sel_q + 3'd1;
`ifdef MUX8_ARB_TIMEOUT_EN
          hold_cnt_d = 8'd0;
`endif
          if (win_found) begin
            sel_d = win_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
`ifdef MUX8_ARB_TIMEOUT_EN
          if (hold_cnt_q == HOLD_LAST) begin
            // At the limit: rotate only if someone else is waiting.
            // Otherwise keep the owner and hold the counter at the limit.
            if (win_found) begin
              ptr_d      = sel_q + 3'd1;
              sel_d      = win_idx;
              hold_cnt_d = 8'd0;
              preempt_d  = 1'b1;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs come from the next state, so grant never lags select.
  always_comb begin
    gnt_valid_d = (state_d == ST_GRANT);
    gnt_d       = gnt_valid_d ? (8'b1 << sel_d) : 8'h00;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 3'd0;
      sel_q       <= 3'd0;
      gnt_q       <= 8'h00;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
      hold_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
`ifdef MUX8_ARB_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule
`default_nettype wire

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

- Round-robin arbiter and select controller for the 8:1 multiplexer datapath.
- Shares the eight mux data inputs among eight requesters: each requester gets exclusive ownership of the mux select until it releases its request.
- Drives the 3-bit select and a one-hot grant vector; rotating priority ensures no requester starves.
- Sits between requester logic and the mux, replacing free-running select sweeps with a demand-driven schedule.

## Interface
Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles before forced rotation (only used with the timeout feature); legal range 2..255.

Ports:
- clk  input  1  rising-edge clock. One clock domain.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request per requester; req[i] owns mux data input i.
- sel  output  3  mux select; encodes current owner index.
- gnt  output  8  one-hot grant; all-zero when idle.
- gnt_valid  output  1  high while a requester owns the mux.
- preempt  output  1  one-cycle pulse on a timeout-forced rotation.

## Operation
- States: IDLE (no owner), GRANT (owner = sel).
- Rotating pointer ptr[2:0] gives the highest-priority index. Winner = first i with req[i]=1, searching ptr, ptr+1, … mod 8.
- IDLE:
  - If any req bit is 1, the next edge moves to GRANT, loads sel = winner and sets gnt = 1<<winner, gnt_valid = 1.
  - Otherwise the arbiter stays in IDLE.
- GRANT with req[sel] = 1: hold owner; sel and gnt remain stable.
- GRANT with req[sel] = 0 (release):
  - ptr = sel+1 mod 8.
  - If any other req is set, the next edge grants the new winner (searched from the new ptr) directly, with no idle bubble.
  - Otherwise the next edge goes to IDLE and clears gnt and gnt_valid.
- Pointer wrap: owner 7 releases -> ptr = 0.
- Same-cycle events:
  - A release and new requests arriving in the same cycle are arbitrated together at the next edge.
  - A requester that drops and re-raises req between samples is not seen as a release.
- In IDLE, sel retains the last owner value. sel has no meaning while gnt_valid = 0.
- Invariant: gnt == (gnt_valid ? 1<<sel : 0) at all times.

## Timing
- Reset values (edge where rst = 1): state IDLE, ptr = 0, sel = 0, gnt = 8'h00, gnt_valid = 0, preempt = 0, hold counter = 0.
- Reset mid-grant: outputs go to reset values at that edge. After reset, arbitration restarts with priority from index 0.
- Grant latency: req sampled at edge N -> gnt/sel valid after edge N (1 cycle).
- Release latency: req[sel] sampled low at edge N -> new owner or idle after edge N.
- All outputs are registered. There is no combinational path from req to any output.

## Configuration
- Macro: MUX8_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit hold counter clears on every new grant and increments each cycle in GRANT.
  - When counter == MAX_HOLD-1 and at least one other req is set, the next edge:
    - sets ptr = sel+1 mod 8;
    - grants the winner excluding the current owner;
    - clears the counter and pulses preempt for 1 cycle.
  - If no other req is set, the owner keeps the grant and the counter saturates at MAX_HOLD-1.
- Without the macro: no counter; an owner holds the grant indefinitely while req[sel] = 1, and preempt is tied 0.

## Test plan
- Reset then idle: rst high 2 cycles, req = 8'h00 for 5 cycles -> gnt = 8'h00, gnt_valid = 0, sel = 0 throughout.
- Single request: req = 8'h10 -> one cycle later gnt = 8'h10, sel = 4. Drop req -> next cycle gnt = 8'h00, gnt_valid = 0.
- Round-robin fairness:
  - Drive req = 8'hFF; each owner releases one cycle after being granted, then re-requests.
  - Required: sel sequence 0,1,…,7,0, and no index is granted twice before all others.
- Wrap and no-bubble handoff: ptr = 7, req = 8'h81, owner 7 releases -> next cycle sel = 0, gnt = 8'h01 with gnt_valid never dropping.
- Mid-grant reset: owner 5 granted, assert rst one cycle with req = 8'h24 held -> gnt clears. Next grant is index 2 (ptr = 0), not 5.
- Timeout (MUX8_ARB_TIMEOUT_EN, MAX_HOLD = 4):
  - Hold req = 8'h03 with owner 0 -> after 4 grant cycles, preempt = 1 for one cycle and gnt = 8'h02.
  - With req = 8'h01 alone, owner 0 is never preempted.
